// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg: shared state encodings, reset/exception constants and requester codes
// for the fetch-stage PC sequencing controller.
package pc_seq_ctrl_pkg;

    localparam logic [31:0] INIT_32        = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_EXC,
        REQ_REDIR,
        REQ_WAIT,
        REQ_STALL
    } req_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: pipeline-side requests into the PC sequencer and its PC-register controls.
// master = pipeline/requesters, slave = the controller.
interface pc_seq_ctrl_if;

    logic [31:0] pc_cur;
    logic        imem_ready;
    logic        ld_use_stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_req;
    logic [31:0] pc_next;
    logic        pc_pause;
    logic        flush_ifid;
    logic        flush_idex;
    logic [1:0]  ctrl_state;

    modport master (
        output pc_cur, imem_ready, ld_use_stall, redir_valid, redir_target, exc_req,
        input  pc_next, pc_pause, flush_ifid, flush_idex, ctrl_state
    );

    modport slave (
        input  pc_cur, imem_ready, ld_use_stall, redir_valid, redir_target, exc_req,
        output pc_next, pc_pause, flush_ifid, flush_idex, ctrl_state
    );

endinterface

// File: rtl/pc_seq_ctrl_prio.sv
// pc_seq_prio: combinational requester priority (exception > redirect > imem wait > load-use).
// In HOLD the squashed redirect and stall requests are masked; only an exception can re-target.
module pc_seq_prio
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        hold_i,
    input  logic        exc_req_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_target_i,
    input  logic        imem_ready_i,
    input  logic        ld_use_stall_i,
    output req_e        req_o,
    output logic [31:0] target_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o
);

    assign req_o = exc_req_i                    ? REQ_EXC   :
                   (redir_valid_i && !hold_i)   ? REQ_REDIR :
                   !imem_ready_i                ? REQ_WAIT  :
                   (ld_use_stall_i && !hold_i)  ? REQ_STALL : REQ_NONE;

    assign target_o     = exc_req_i ? EXC_VECTOR : redir_target_i;
    assign flush_ifid_o = (req_o == REQ_EXC) || (req_o == REQ_REDIR);
    assign flush_idex_o = flush_ifid_o || (req_o == REQ_STALL);

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch-stage PC sequencing FSM (RUN/WAIT/HOLD) holding redirects across imem waits.
// Optional PC_SEQ_STALL_CNT_EN adds saturating stall_cycles and redir_count outputs.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = INIT_32,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned INSTR_BYTES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_seq_ctrl_if.slave bus
`ifdef PC_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  redir_count
`endif
);

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pc_next_c, target;
    logic        pause_c, flush_ifid_c, flush_idex_c;
    req_e        req;

    pc_seq_prio #(.EXC_VECTOR(EXC_VECTOR)) u_prio (
        .hold_i         (state_q == ST_HOLD),
        .exc_req_i      (bus.exc_req),
        .redir_valid_i  (bus.redir_valid),
        .redir_target_i (bus.redir_target),
        .imem_ready_i   (bus.imem_ready),
        .ld_use_stall_i (bus.ld_use_stall),
        .req_o          (req),
        .target_o       (target),
        .flush_ifid_o   (flush_ifid_c),
        .flush_idex_o   (flush_idex_c)
    );

    // WAIT re-evaluates the RUN rules every cycle, so it needs no branch of its own.
    always_comb begin
        state_d   = ST_RUN;
        pend_d    = pend_q;
        pc_next_c = bus.pc_cur + 32'(INSTR_BYTES);
        pause_c   = 1'b0;
        if (flush_ifid_c) begin
            pc_next_c = bus.imem_ready ? target : bus.pc_cur;
            pause_c   = !bus.imem_ready;
            state_d   = bus.imem_ready ? ST_RUN : ST_HOLD;
            pend_d    = bus.imem_ready ? pend_q : target;
        end else if (state_q == ST_HOLD) begin
            pc_next_c = bus.imem_ready ? pend_q : bus.pc_cur;
            pause_c   = !bus.imem_ready;
            state_d   = bus.imem_ready ? ST_RUN : ST_HOLD;
        end else if (req == REQ_WAIT) begin
            pc_next_c = bus.pc_cur;
            pause_c   = 1'b1;
            state_d   = ST_WAIT;
        end else if (req == REQ_STALL) begin
            pc_next_c = bus.pc_cur;
            pause_c   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pend_q  <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.pc_next    = rst ? RESET_VECTOR : pc_next_c;
    assign bus.pc_pause   = !rst && pause_c;
    assign bus.flush_ifid = rst || flush_ifid_c;
    assign bus.flush_idex = rst || flush_idex_c;
    assign bus.ctrl_state = state_q;

`ifdef PC_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, redir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (pause_c && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (flush_ifid_c && redir_q != '1) redir_q <= redir_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign redir_count  = redir_q;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: table-driven scoreboard bench for pc_seq_ctrl plus hand-written
// wait/counter sequences; counter checks apply when PC_SEQ_STALL_CNT_EN is defined.
module tb_pc_seq_ctrl;

    typedef struct {
        logic        rst;
        logic        ir;
        logic        ld;
        logic        rv;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] e_next;
        logic        e_pause;
        logic        e_fi;
        logic        e_fe;
        logic [1:0]  e_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[32];
    vec_t sb[$];

    pc_seq_ctrl_if bus();

`ifdef PC_SEQ_STALL_CNT_EN
    logic [31:0] stall_cycles, redir_count;
    pc_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .stall_cycles(stall_cycles), .redir_count(redir_count));
`else
    pc_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic vec_t v(logic r, logic ir, logic ld, logic rv, logic exc, logic [31:0] pc,
                               logic [31:0] tgt, logic [31:0] nx, logic p, logic fi, logic fe, logic [1:0] st);
        vec_t t;
        t = '{rst: r, ir: ir, ld: ld, rv: rv, exc: exc, pc: pc, tgt: tgt,
              e_next: nx, e_pause: p, e_fi: fi, e_fe: fe, e_st: st};
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic ir, logic ld, logic rv, logic exc, logic [31:0] pc, logic [31:0] tgt);
        rst              = r;
        bus.imem_ready   = ir;
        bus.ld_use_stall = ld;
        bus.redir_valid  = rv;
        bus.exc_req      = exc;
        bus.pc_cur       = pc;
        bus.redir_target = tgt;
    endtask

    initial begin
        vec_t e;
        //           rst ir ld rv ex pc            tgt           next          p  fi fe st
        tv[0]  = v(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1, 0);
        tv[1]  = v(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1, 0);
        tv[2]  = v(0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 0, 0, 0);
        tv[3]  = v(0, 1, 0, 0, 0, 32'h4,        32'h0,        32'h8,        0, 0, 0, 0);
        tv[4]  = v(0, 1, 0, 0, 0, 32'h8,        32'h0,        32'hC,        0, 0, 0, 0);
        tv[5]  = v(0, 1, 0, 1, 0, 32'hC,        32'h100,      32'h100,      0, 1, 1, 0);
        tv[6]  = v(0, 1, 0, 0, 0, 32'h100,      32'h0,        32'h104,      0, 0, 0, 0);
        tv[7]  = v(0, 0, 0, 1, 0, 32'h104,      32'h300,      32'h104,      1, 1, 1, 0);
        tv[8]  = v(0, 0, 0, 0, 0, 32'h104,      32'h0,        32'h104,      1, 0, 0, 2);
        tv[9]  = v(0, 0, 0, 1, 0, 32'h104,      32'h500,      32'h104,      1, 0, 0, 2);
        tv[10] = v(0, 1, 0, 0, 0, 32'h104,      32'h0,        32'h300,      0, 0, 0, 2);
        tv[11] = v(0, 1, 0, 0, 0, 32'h300,      32'h0,        32'h304,      0, 0, 0, 0);
        tv[12] = v(0, 1, 0, 1, 1, 32'h304,      32'h200,      32'h180,      0, 1, 1, 0);
        tv[13] = v(0, 1, 0, 0, 0, 32'h180,      32'h0,        32'h184,      0, 0, 0, 0);
        tv[14] = v(0, 1, 1, 0, 0, 32'h40,       32'h0,        32'h40,       1, 0, 1, 0);
        tv[15] = v(0, 1, 0, 0, 0, 32'h40,       32'h0,        32'h44,       0, 0, 0, 0);
        tv[16] = v(0, 1, 1, 1, 0, 32'h44,       32'h80,       32'h80,       0, 1, 1, 0);
        tv[17] = v(0, 0, 0, 0, 0, 32'h80,       32'h0,        32'h80,       1, 0, 0, 0);
        tv[18] = v(0, 0, 0, 0, 0, 32'h80,       32'h0,        32'h80,       1, 0, 0, 1);
        tv[19] = v(0, 0, 0, 0, 1, 32'h80,       32'h0,        32'h80,       1, 1, 1, 1);
        tv[20] = v(0, 0, 0, 1, 0, 32'h80,       32'h900,      32'h80,       1, 0, 0, 2);
        tv[21] = v(0, 1, 0, 0, 0, 32'h80,       32'h0,        32'h180,      0, 0, 0, 2);
        tv[22] = v(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 0, 0, 0);
        tv[23] = v(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0);
        tv[24] = v(0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 0, 0, 1);
        tv[25] = v(0, 1, 0, 0, 0, 32'h4,        32'h0,        32'h8,        0, 0, 0, 0);
        tv[26] = v(0, 0, 0, 1, 0, 32'h8,        32'h600,      32'h8,        1, 1, 1, 0);
        tv[27] = v(0, 0, 0, 0, 1, 32'h8,        32'h0,        32'h8,        1, 1, 1, 2);
        tv[28] = v(0, 1, 0, 0, 0, 32'h8,        32'h0,        32'h180,      0, 0, 0, 2);
        tv[29] = v(0, 0, 0, 1, 0, 32'h180,      32'h700,      32'h180,      1, 1, 1, 0);
        tv[30] = v(1, 0, 0, 0, 0, 32'h180,      32'h0,        32'h0,        0, 1, 1, 2);
        tv[31] = v(0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 0, 0, 0);

        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            drive(tv[i].rst, tv[i].ir, tv[i].ld, tv[i].rv, tv[i].exc, tv[i].pc, tv[i].tgt);
            sb.push_back(tv[i]);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d pc_next", i), bus.pc_next, e.e_next);
            check($sformatf("v%0d pc_pause", i), 32'(bus.pc_pause), 32'(e.e_pause));
            check($sformatf("v%0d flush_ifid", i), 32'(bus.flush_ifid), 32'(e.e_fi));
            check($sformatf("v%0d flush_idex", i), 32'(bus.flush_idex), 32'(e.e_fe));
            check($sformatf("v%0d ctrl_state", i), 32'(bus.ctrl_state), 32'(e.e_st));
            @(posedge clk); #1;
        end

        // Five paused imem-wait cycles after reset, then an accepted redirect.
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 32'h20, 32'h0);
            @(negedge clk);
            check($sformatf("wait%0d pause", i), 32'(bus.pc_pause), 32'd1);
            check($sformatf("wait%0d state", i), 32'(bus.ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("wait%0d pc_next", i), bus.pc_next, 32'h20);
            @(posedge clk); #1;
        end
        drive(0, 1, 0, 1, 0, 32'h20, 32'h1000);
        @(negedge clk);
        check("wait_release pc_next", bus.pc_next, 32'h1000);
        check("wait_release pause", 32'(bus.pc_pause), 32'd0);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 32'h1000, 32'h0);
        @(negedge clk);
        check("after_release pc_next", bus.pc_next, 32'h1004);
        check("after_release state", 32'(bus.ctrl_state), 32'd0);
`ifdef PC_SEQ_STALL_CNT_EN
        check("stall_cycles", stall_cycles, 32'd5);
        check("redir_count", redir_count, 32'd1);
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_cycles_clr", stall_cycles, 32'd0);
        check("redir_count_clr", redir_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencing controller for the fetch-stage PC register.
- Drives the register's next-PC value and pause input.
- Arbitrates four PC requesters: exception, EX-stage branch/jump redirect, ID-stage load-use stall, and instruction-memory wait.
- Generates IF/ID and ID/EX flushes; holds a redirect target across instruction-memory wait cycles so no redirect is lost.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value driven while reset is asserted (matches the shared INIT_32 constant).
- EXC_VECTOR, 32'h0000_0180, exception handler entry address.
- INSTR_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  32  current PC register output.
- imem_ready  in  1  instruction memory accepted/returned the fetch this cycle.
- ld_use_stall  in  1  ID-stage load-use hazard; hold PC and IF/ID.
- redir_valid  in  1  EX-stage taken branch or jump.
- redir_target  in  32  redirect address; valid with redir_valid.
- exc_req  in  1  exception raised; vector to EXC_VECTOR.
- pc_next  out  32  next-PC value to the PC register.
- pc_pause  out  1  PC register hold.
- flush_ifid  out  1  squash the IF/ID stage.
- flush_idex  out  1  squash the ID/EX stage.
- ctrl_state  out  2  debug view of the FSM state.

Behaviour:
- Outputs are combinational from the state, pend_pc and inputs. State and pend_pc are registered; clk is the only clock.
- Reset: while rst=1, the controller drives:
  - pc_next=RESET_VECTOR, pc_pause=0
  - flush_ifid=1, flush_idex=1
  - state←RUN, pend_pc←RESET_VECTOR at the edge
- A reset mid-operation discards any pending redirect.
- Requester priority: exc_req > redir_valid > imem wait > ld_use_stall > sequential.
- States (ctrl_state encoding): RUN=0, WAIT=1, HOLD=2. Encoding 3 is illegal and returns to RUN.
- RUN:
  - exc_req=1: target=EXC_VECTOR; flush_ifid=1, flush_idex=1.
  - Else redir_valid=1: target=redir_target; flush_ifid=1, flush_idex=1.
  - Either redirect with imem_ready=1: pc_next=target, pause=0, stay RUN.
  - Either redirect with imem_ready=0: pend_pc←target, pause=1, go to HOLD.
  - Else imem_ready=0: pause=1, pc_next=pc_cur, go to WAIT.
  - Else ld_use_stall=1: pause=1, flush_idex=1 (inserts a bubble), flush_ifid=0, stay RUN.
  - Else: pc_next=pc_cur+INSTR_BYTES (32-bit, wraps mod 2^32), pause=0.
- WAIT:
  - pause=1 until imem_ready=1.
  - On imem_ready=1, release with the RUN rules evaluated in that cycle and return to RUN.
  - A redirect or exception arriving in WAIT with imem_ready=0: capture into pend_pc, assert both flushes, go to HOLD.
- HOLD:
  - pause=1, flushes 0 (already issued).
  - A new exc_req overwrites pend_pc with EXC_VECTOR and flushes again. A new redir_valid is ignored, since the redirecting instruction was already squashed.
  - On imem_ready=1: pc_next=pend_pc, pause=0, go to RUN.
- Simultaneous exc_req and redir_valid: the exception wins; the redirect is dropped.
- Simultaneous ld_use_stall and redir_valid: the redirect wins; the stall is ignored because the stalled instruction is flushed.
- Latency: a redirect is visible in the PC register one cycle after redir_valid when imem_ready=1.

Optional Feature:
- Macro: PC_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles[31:0], a saturating count of cycles with pc_pause=1 and rst=0.
  - Adds output redir_count[31:0], a saturating count of accepted redirects and exceptions.
  - Both counters clear on rst.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared const header/package:
  - state encodings ST_RUN, ST_WAIT, ST_HOLD
  - INIT_32
  - default EXC_VECTOR
- One natural sub-module: pc_seq_prio, a purely combinational requester-priority encoder producing target select and flush enables. The FSM and pend_pc remain in pc_seq_ctrl.

Test Plan:
- Reset then free run: rst=1 for 2 cycles, then imem_ready=1 → pc_next=0x0 during reset; 0x4, 0x8, 0xC on successive cycles; pause=0.
- Taken branch: redir_valid=1, redir_target=0x100, imem_ready=1 → pc_next=0x100, both flushes=1 for one cycle, next cycle pc_next=0x104.
- Redirect during imem wait: imem_ready=0 for 3 cycles with redir_valid pulsed at the first → HOLD, pause=1 for 3 cycles, flushes only in the first; on imem_ready=1, pc_next=target.
- Exception vs. branch in the same cycle: exc_req=1, redir_valid=1, target 0x200 → pc_next=0x180, redirect lost.
- Load-use stall: ld_use_stall=1 for 1 cycle at pc_cur=0x40 → pause=1, flush_idex=1, flush_ifid=0; next cycle pc_next=0x44.
- Wrap and counter: pc_cur=0xFFFF_FFFC → pc_next=0x0. With PC_SEQ_STALL_CNT_EN defined, 5 paused cycles → stall_cycles=5.
